bram_stream_reader: RTL and testbench

- Read-side initiator for the single-port `bram` block. It drives `bram`'s ena/wr_ena/addr pins and consumes its 1-cycle registered read data.
- It fetches `count` consecutive words starting at a base address and emits them on a valid/ready stream. The stream feeds neuron MAC lanes with weights and activations.
- It absorbs `bram`'s fixed read latency and output backpressure with a 2-entry buffer, and sustains 1 word/cycle when the consumer never stalls.

---
 rtl/bram_stream_reader.sv | 230 +++++++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: read-side initiator for the single-port bram block.
// It fetches count consecutive words from base (wrapping at the top of the
// address space) and emits them on a valid/ready stream. A 2-entry buffer
// absorbs the 1-cycle BRAM read latency and output backpressure.
// Optional build macro BRAM_STREAM_READER_LAST_EN adds a last_o stream flag.
module bram_stream_reader #(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 16
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic [ADDR_LEN-1:0] base_addr_i,
  input  logic [ADDR_LEN:0]   count_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                bram_ena_o,
  output logic                bram_wr_ena_o,
  output logic [ADDR_LEN-1:0] bram_addr_o,
  output logic [WORD_LEN-1:0] bram_data_o,
  input  logic [WORD_LEN-1:0] bram_data_i,
  output logic [WORD_LEN-1:0] data_o,
  output logic                valid_o,
  input  logic                ready_i
`ifdef BRAM_STREAM_READER_LAST_EN
  ,
  output logic                last_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_LEN:0] CNT_ZERO = {(ADDR_LEN+1){1'b0}};
  localparam logic [ADDR_LEN:0] CNT_ONE  = {{ADDR_LEN{1'b0}}, 1'b1};

  state_t              state_r;
  logic                busy_r;
  logic                done_r;
  logic [ADDR_LEN-1:0] base_r;
  logic [ADDR_LEN:0]   count_r;
  logic [ADDR_LEN:0]   issued_r;
  logic                inflight_r;

  // Shift-style buffer: head_r is always the word presented on the stream.
  logic [WORD_LEN-1:0] head_r;
  logic [WORD_LEN-1:0] tail_r;
  logic [1:0]          occ_r;
  logic                valid_r;

`ifdef BRAM_STREAM_READER_LAST_EN
  logic                inflight_last_r;
  logic                head_last_r;
  logic                tail_last_r;
`endif

  logic                pop_s;
  logic                push_s;
  logic                issue_s;
  logic                last_issue_s;
  logic [2:0]          pending_s;
  logic [ADDR_LEN:0]   issued_inc_s;

  // Issue decision: only read when the word is guaranteed a buffer slot.
  always_comb begin
    pop_s        = valid_r & ready_i;
    push_s       = inflight_r;
    pending_s    = {1'b0, occ_r} + {2'b00, inflight_r};
    issued_inc_s = issued_r + CNT_ONE;
    last_issue_s = (issued_inc_s == count_r);
    if (state_r == ST_READ) begin
      issue_s = (issued_r < count_r) && ((pending_s - {2'b00, pop_s}) < 3'd2);
    end else begin
      issue_s = 1'b0;
    end
  end

  // Burst control FSM: IDLE -> READ -> DRAIN -> DONE -> IDLE.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      base_r     <= {ADDR_LEN{1'b0}};
      count_r    <= CNT_ZERO;
      issued_r   <= CNT_ZERO;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            busy_r <= 1'b1;
            if (count_i != CNT_ZERO) begin
              base_r   <= base_addr_i;
              count_r  <= count_i;
              issued_r <= CNT_ZERO;
              done_r   <= 1'b0;
              state_r  <= ST_READ;
            end else begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        ST_READ: begin
          if (issue_s) begin
            issued_r <= issued_inc_s;
            if (last_issue_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Leave as soon as the buffer empties this cycle so done_o follows
          // the final handshake directly.
          if (!inflight_r && ((occ_r == 2'd0) || ((occ_r == 2'd1) && pop_s))) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Two-entry output buffer; captures BRAM data one cycle after each issue.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      head_r  <= {WORD_LEN{1'b0}};
      tail_r  <= {WORD_LEN{1'b0}};
      occ_r   <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_r <= bram_data_i;
          end else begin
            tail_r <= bram_data_i;
          end
          occ_r   <= occ_r + 2'd1;
          valid_r <= 1'b1;
        end
        2'b01: begin
          head_r  <= tail_r;
          occ_r   <= occ_r - 2'd1;
          valid_r <= (occ_r == 2'd2);
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            head_r <= bram_data_i;
          end else begin
            head_r <= tail_r;
            tail_r <= bram_data_i;
          end
          valid_r <= 1'b1;
        end
        default: begin
          valid_r <= (occ_r != 2'd0);
        end
      endcase
    end
  end

`ifdef BRAM_STREAM_READER_LAST_EN
  // Per-entry final-word flag travelling alongside the data buffer.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      inflight_last_r <= 1'b0;
      head_last_r     <= 1'b0;
      tail_last_r     <= 1'b0;
    end else begin
      inflight_last_r <= issue_s & last_issue_s;
      case ({push_s, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            head_last_r <= inflight_last_r;
          end else begin
            tail_last_r <= inflight_last_r;
          end
        end
        2'b01: begin
          head_last_r <= (occ_r == 2'd2) ? tail_last_r : 1'b0;
          tail_last_r <= 1'b0;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            head_last_r <= inflight_last_r;
          end else begin
            head_last_r <= tail_last_r;
            tail_last_r <= inflight_last_r;
          end
        end
        default: begin
          head_last_r <= head_last_r;
        end
      endcase
    end
  end

  assign last_o = head_last_r;
`endif

  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign bram_ena_o    = issue_s;
  assign bram_wr_ena_o = 1'b0;
  assign bram_addr_o   = base_r + issued_r[ADDR_LEN-1:0];
  assign bram_data_o   = {WORD_LEN{1'b0}};
  assign data_o        = head_r;
  assign valid_o       = valid_r;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: BRAM model with mem[i]=i+100,
// scoreboard of expected words/addresses per accepted burst, directed
// latency/boundary scenarios followed by randomized bursts.
module tb_bram_stream_reader;
  localparam int AL = 8;
  localparam int WL = 16;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic          start_i;
  logic [AL-1:0] base_addr_i;
  logic [AL:0]   count_i;
  logic          busy_o;
  logic          done_o;
  logic          bram_ena_o;
  logic          bram_wr_ena_o;
  logic [AL-1:0] bram_addr_o;
  logic [WL-1:0] bram_data_o;
  logic [WL-1:0] bram_data_i;
  logic [WL-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
`ifdef BRAM_STREAM_READER_LAST_EN
  logic          last_o;
`endif

  always #5 clk_i = ~clk_i;

  bram_stream_reader #(.ADDR_LEN(AL), .WORD_LEN(WL)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i),
    .base_addr_i(base_addr_i), .count_i(count_i),
    .busy_o(busy_o), .done_o(done_o),
    .bram_ena_o(bram_ena_o), .bram_wr_ena_o(bram_wr_ena_o),
    .bram_addr_o(bram_addr_o), .bram_data_o(bram_data_o),
    .bram_data_i(bram_data_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
`ifdef BRAM_STREAM_READER_LAST_EN
    , .last_o(last_o)
`endif
  );

  // BRAM model: registered read, returns 0 when not enabled.
  logic [WL-1:0] mem [256];
  always @(posedge clk_i) bram_data_i <= bram_ena_o ? mem[bram_addr_o] : '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int outstanding = 0;
  int hs_count = 0;
  bit busy_m = 1'b0;
  bit done_due = 1'b0;
  bit prev_stall = 1'b0;
  bit rst_seen = 1'b0;
  logic [WL-1:0] prev_data = '0;
  logic [WL-1:0] exp_q[$];
  logic [AL-1:0] addr_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic rdy_for(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 9) < 6);
    return ((cyc % 3) == 0);
  endfunction

  // One clock cycle: drive inputs at negedge, check outputs, update the model.
  task automatic cycle(input logic rst_n, input logic st, input logic [AL-1:0] base,
                       input logic [AL:0] cnt, input logic rdy);
    logic hs;
    bit   done_nxt;
    bit   busy_nxt;
    @(negedge clk_i);
    reset_ni = rst_n; start_i = st; base_addr_i = base; count_i = cnt; ready_i = rdy;
    #1;
    cyc++;
    hs = valid_o & ready_i;
    check_val("wr_ena_const", 32'(bram_wr_ena_o), 32'd0);
    check_val("bram_wdata_const", 32'(bram_data_o), 32'd0);
    check_val("busy", 32'(busy_o), 32'(busy_m));
    check_val("done", 32'(done_o), 32'(done_due));
    if (rst_seen) begin
      check_val("rst_valid", 32'(valid_o), 32'd0);
      check_val("rst_data", 32'(data_o), 32'd0);
      check_val("rst_ena", 32'(bram_ena_o), 32'd0);
      check_val("rst_addr", 32'(bram_addr_o), 32'd0);
    end
    if (prev_stall) begin
      check_val("hold_valid", 32'(valid_o), 32'd1);
      check_val("hold_data", 32'(data_o), 32'(prev_data));
    end
    if (bram_ena_o) begin
      check_val("occ_rule", 32'((outstanding - int'(hs)) < 2), 32'd1);
      check_val("ena_expected", 32'(addr_q.size() != 0), 32'd1);
      if (addr_q.size() != 0) check_val("addr", 32'(bram_addr_o), 32'(addr_q.pop_front()));
    end
`ifdef BRAM_STREAM_READER_LAST_EN
    check_val("last", 32'(last_o), 32'(valid_o && (exp_q.size() == 1)));
`endif
    done_nxt = 1'b0;
    if (hs) begin
      hs_count++;
      check_val("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check_val("data", 32'(data_o), 32'(exp_q.pop_front()));
        if (exp_q.size() == 0) done_nxt = 1'b1;
      end
    end
    outstanding = outstanding + int'(bram_ena_o) - int'(hs);
    busy_nxt = done_due ? 1'b0 : busy_m;
    if (st && !busy_m) begin
      for (int k = 0; k < int'(cnt); k++) begin
        logic [AL-1:0] a;
        a = base + AL'(k);
        addr_q.push_back(a);
        exp_q.push_back(mem[a]);
      end
      busy_nxt = 1'b1;
      if (cnt == '0) done_nxt = 1'b1;
    end
    prev_stall = valid_o && !ready_i;
    prev_data = data_o;
    rst_seen = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      addr_q.delete();
      outstanding = 0;
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      prev_stall = 1'b0;
      rst_seen = 1'b1;
    end
    busy_m = busy_nxt;
    done_due = done_nxt;
  endtask

  // Run until the model expects the burst to be over, with a cycle budget.
  task automatic finish_burst(input int mode);
    int n;
    n = 0;
    while (busy_m && n < 2000) begin
      cycle(1'b1, (mode == 1) && ($urandom_range(0, 5) == 0), AL'($urandom),
            9'($urandom_range(0, 20)), rdy_for(mode));
      n++;
    end
    check_val("burst_timeout", 32'(busy_m), 32'd0);
  endtask

  task automatic run_burst(input logic [AL-1:0] base, input logic [AL:0] cnt, input int mode);
    hs_count = 0;
    cycle(1'b1, 1'b1, base, cnt, rdy_for(mode));
    finish_burst(mode);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = WL'(i + 100);
    reset_ni = 1'b0; start_i = 1'b0; base_addr_i = '0; count_i = '0; ready_i = 1'b1;

    // Reset state
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    cycle(1'b1, 1'b0, '0, '0, 1'b1);

    // Basic burst: base=4, count=5, ready held high; exact cycle timing
    cycle(1'b1, 1'b1, 8'd4, 9'd5, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b1, 1'b0, '0, '0, 1'b1);
      check_val("basic_ena", 32'(bram_ena_o), 32'(k >= 1 && k <= 5));
      check_val("basic_valid", 32'(valid_o), 32'(k >= 3 && k <= 7));
      if (k >= 3 && k <= 7) check_val("basic_data", 32'(data_o), 32'(104 + k - 3));
      check_val("basic_done", 32'(done_o), 32'(k == 8));
    end
    check_val("basic_busy_after", 32'(busy_o), 32'd0);

    // Backpressure: ready toggles 1,0,0,1,...
    run_burst(8'd0, 9'd4, 2);
    check_val("bp_handshakes", 32'(hs_count), 32'd4);

    // Address wrap past the top of memory
    run_burst(8'd254, 9'd4, 0);
    check_val("wrap_handshakes", 32'(hs_count), 32'd4);

    // Zero count: done in cycle 1, no reads, no stream
    cycle(1'b1, 1'b1, 8'd7, 9'd0, 1'b1);
    cycle(1'b1, 1'b0, '0, '0, 1'b1);
    check_val("zero_done", 32'(done_o), 32'd1);
    check_val("zero_valid", 32'(valid_o), 32'd0);
    cycle(1'b1, 1'b0, '0, '0, 1'b1);
    check_val("zero_busy_after", 32'(busy_o), 32'd0);
    check_val("zero_valid_after", 32'(valid_o), 32'd0);

    // Reset mid-burst, then a fresh burst
    cycle(1'b1, 1'b1, 8'd0, 9'd10, 1'b1);
    for (int k = 1; k <= 3; k++) cycle(1'b1, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    for (int k = 5; k <= 7; k++) begin
      cycle(1'b1, 1'b0, '0, '0, 1'b1);
      check_val("rst_stale_valid", 32'(valid_o), 32'd0);
      check_val("rst_busy", 32'(busy_o), 32'd0);
    end
    run_burst(8'd20, 9'd2, 0);
    check_val("post_rst_handshakes", 32'(hs_count), 32'd2);

    // Start while busy is ignored
    hs_count = 0;
    cycle(1'b1, 1'b1, 8'd30, 9'd3, 1'b1);
    cycle(1'b1, 1'b0, '0, '0, 1'b1);
    cycle(1'b1, 1'b1, 8'd50, 9'd2, 1'b1);
    finish_burst(0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, '0, '0, 1'b1);
    check_val("busy_start_handshakes", 32'(hs_count), 32'd3);

    // Full address-space burst
    run_burst(8'd17, 9'd256, 0);
    check_val("full_handshakes", 32'(hs_count), 32'd256);

    // Randomized bursts
    for (int b = 0; b < 40; b++) begin
      logic [AL:0] cnt;
      int mode;
      cnt = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 3)) : 9'($urandom_range(1, 24));
      mode = int'($urandom_range(0, 2));
      run_burst(AL'($urandom), cnt, mode);
      check_val("rand_handshakes", 32'(hs_count), 32'(cnt));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        cycle(1'b1, 1'b0, '0, '0, rdy_for(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
